// File: rtl/pipe_flow_ctrl_pkg.sv
// Shared types for the pipeline flow controller: state encoding and
// per-rule stall/flush masks (stall: pc,ifid,idex,exmem,memwb; flush: ifid..memwb).
package rv_fc_pkg;

  localparam logic FC_RUN  = 1'b0;
  localparam logic FC_PEND = 1'b1;

  typedef enum logic {
    ST_RUN  = FC_RUN,
    ST_PEND = FC_PEND
  } fc_state_e;

  // bit 0 is the earliest stage in both fields
  typedef struct packed {
    logic [4:0] stall;
    logic [3:0] flush;
  } fc_mask_t;

  localparam fc_mask_t MASK_NONE = '{
    stall: 5'b00000, flush: 4'b0000
  };
  localparam fc_mask_t MASK_MEMBUSY = '{
    stall: 5'b01111, flush: 4'b1000
  };
  localparam fc_mask_t MASK_EXBUSY = '{
    stall: 5'b00111, flush: 4'b0100
  };
  localparam fc_mask_t MASK_BR = '{
    stall: 5'b00000, flush: 4'b0011
  };
  localparam fc_mask_t MASK_LDUSE = '{
    stall: 5'b00011, flush: 4'b0010
  };
  localparam fc_mask_t MASK_TRAP = '{
    stall: 5'b00000, flush: 4'b1111
  };

endpackage

// File: rtl/pipe_flow_ctrl_if.sv
// Flow-control bundle between the controller and the pipeline stages.
// FC_PERF_CNT_EN adds the perf-counter clear input and counter outputs.
interface pipe_flow_ctrl_if #(
  parameter int PC_W = 32
`ifdef FC_PERF_CNT_EN
  ,
  parameter int PERF_W = 32
`endif
);
  logic            id_ld_hazard_i;
  logic            ex_busy_i;
  logic            ex_br_taken_i;
  logic [PC_W-1:0] ex_br_target_i;
  logic            mem_busy_i;
  logic            csr_trap_i;
  logic [PC_W-1:0] csr_trap_pc_i;
  logic            csr_mret_i;
  logic [PC_W-1:0] csr_mepc_i;

  logic            fc_stall_pc_o;
  logic            fc_stall_ifid_o;
  logic            fc_stall_idex_o;
  logic            fc_stall_exmem_o;
  logic            fc_stall_memwb_o;
  logic            fc_flush_ifid_o;
  logic            fc_flush_idex_o;
  logic            fc_flush_exmem_o;
  logic            fc_flush_memwb_o;
  logic            fc_redirect_o;
  logic [PC_W-1:0] fc_redirect_pc_o;
  logic            fc_busy_o;

`ifdef FC_PERF_CNT_EN
  logic              fc_perf_clr_i;
  logic [PERF_W-1:0] fc_stall_cyc_o;
  logic [PERF_W-1:0] fc_flush_evt_o;
`endif

  modport master (
    input  id_ld_hazard_i, ex_busy_i,
    input  ex_br_taken_i, ex_br_target_i,
    input  mem_busy_i,
    input  csr_trap_i, csr_trap_pc_i,
    input  csr_mret_i, csr_mepc_i,
`ifdef FC_PERF_CNT_EN
    input  fc_perf_clr_i,
    output fc_stall_cyc_o, fc_flush_evt_o,
`endif
    output fc_stall_pc_o, fc_stall_ifid_o,
    output fc_stall_idex_o, fc_stall_exmem_o,
    output fc_stall_memwb_o,
    output fc_flush_ifid_o, fc_flush_idex_o,
    output fc_flush_exmem_o, fc_flush_memwb_o,
    output fc_redirect_o, fc_redirect_pc_o,
    output fc_busy_o
  );

  modport slave (
    output id_ld_hazard_i, ex_busy_i,
    output ex_br_taken_i, ex_br_target_i,
    output mem_busy_i,
    output csr_trap_i, csr_trap_pc_i,
    output csr_mret_i, csr_mepc_i,
`ifdef FC_PERF_CNT_EN
    output fc_perf_clr_i,
    input  fc_stall_cyc_o, fc_flush_evt_o,
`endif
    input  fc_stall_pc_o, fc_stall_ifid_o,
    input  fc_stall_idex_o, fc_stall_exmem_o,
    input  fc_stall_memwb_o,
    input  fc_flush_ifid_o, fc_flush_idex_o,
    input  fc_flush_exmem_o, fc_flush_memwb_o,
    input  fc_redirect_o, fc_redirect_pc_o,
    input  fc_busy_o
  );

endinterface

// File: rtl/pipe_flow_ctrl_perf_cnt.sv
// Stall-cycle and redirect-event counters; wrap naturally, sync clear
// beats increment. Built only when FC_PERF_CNT_EN is defined.
module fc_perf_cnt #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              stall_inc,
  input  logic              flush_inc,
  output logic [PERF_W-1:0] stall_cyc,
  output logic [PERF_W-1:0] flush_evt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cyc <= '0;
      flush_evt <= '0;
    end else if (clr) begin
      stall_cyc <= '0;
      flush_evt <= '0;
    end else begin
      if (stall_inc)
        stall_cyc <= stall_cyc + PERF_W'(1);
      if (flush_inc)
        flush_evt <= flush_evt + PERF_W'(1);
    end
  end

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller: fixed-priority stall/flush/redirect with a
// pending trap/mret redirect held across MEM back-pressure (opt. FC_PERF_CNT_EN).
module pipe_flow_ctrl
  import rv_fc_pkg::*;
#(
  parameter int PC_W = 32
`ifdef FC_PERF_CNT_EN
  ,
  parameter int PERF_W = 32
`endif
) (
  input  logic clk,
  input  logic rst_n,
  pipe_flow_ctrl_if.master fc
);

  fc_state_e       state;
  fc_state_e       state_nxt;
  logic [PC_W-1:0] pend_pc;
  logic [PC_W-1:0] pend_pc_nxt;

  fc_mask_t        mask;
  logic            redir;
  logic [PC_W-1:0] redir_pc;

  logic            req;
  logic [PC_W-1:0] req_pc;

  assign req    = fc.csr_trap_i | fc.csr_mret_i;
  assign req_pc = fc.csr_trap_i ? fc.csr_trap_pc_i
                                : fc.csr_mepc_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      pend_pc <= '0;
    end else begin
      state   <= state_nxt;
      pend_pc <= pend_pc_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pend_pc_nxt = pend_pc;
    mask        = MASK_NONE;
    redir       = 1'b0;
    redir_pc    = '0;
    unique case (state)
      ST_RUN: begin
        if (req && !fc.mem_busy_i) begin
          mask     = MASK_TRAP;
          redir    = 1'b1;
          redir_pc = req_pc;
        end else if (fc.mem_busy_i) begin
          mask = MASK_MEMBUSY;
          if (req) begin
            pend_pc_nxt = req_pc;
            state_nxt   = ST_PEND;
          end
        end else if (fc.ex_busy_i) begin
          mask = MASK_EXBUSY;
        end else if (fc.ex_br_taken_i) begin
          mask     = MASK_BR;
          redir    = 1'b1;
          redir_pc = fc.ex_br_target_i;
        end else if (fc.id_ld_hazard_i) begin
          mask = MASK_LDUSE;
        end
      end
      ST_PEND: begin
        if (fc.mem_busy_i) begin
          mask = MASK_MEMBUSY;
          // a later trap supersedes; a later mret is dropped
          if (fc.csr_trap_i)
            pend_pc_nxt = fc.csr_trap_pc_i;
        end else begin
          mask      = MASK_TRAP;
          redir     = 1'b1;
          redir_pc  = req ? req_pc : pend_pc;
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  assign fc.fc_stall_pc_o    = rst_n & mask.stall[0];
  assign fc.fc_stall_ifid_o  = rst_n & mask.stall[1];
  assign fc.fc_stall_idex_o  = rst_n & mask.stall[2];
  assign fc.fc_stall_exmem_o = rst_n & mask.stall[3];
  assign fc.fc_stall_memwb_o = rst_n & mask.stall[4];
  assign fc.fc_flush_ifid_o  = rst_n & mask.flush[0];
  assign fc.fc_flush_idex_o  = rst_n & mask.flush[1];
  assign fc.fc_flush_exmem_o = rst_n & mask.flush[2];
  assign fc.fc_flush_memwb_o = rst_n & mask.flush[3];
  assign fc.fc_redirect_o    = rst_n & redir;
  assign fc.fc_redirect_pc_o = rst_n ? redir_pc : '0;
  assign fc.fc_busy_o        = rst_n & (state == ST_PEND);

`ifdef FC_PERF_CNT_EN
  fc_perf_cnt #(
    .PERF_W (PERF_W)
  ) u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (fc.fc_perf_clr_i),
    .stall_inc (fc.fc_stall_pc_o),
    .flush_inc (fc.fc_redirect_o),
    .stall_cyc (fc.fc_stall_cyc_o),
    .flush_evt (fc.fc_flush_evt_o)
  );
`endif

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Bench for pipe_flow_ctrl: directed scenarios then random traffic,
// every cycle checked against a rule-level reference model.
module tb_pipe_flow_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_flow_ctrl_if #(
    .PC_W (32)
`ifdef FC_PERF_CNT_EN
    , .PERF_W (8)
`endif
  ) bus ();

  pipe_flow_ctrl #(
    .PC_W (32)
`ifdef FC_PERF_CNT_EN
    , .PERF_W (8)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fc    (bus)
  );

  typedef struct {
    bit          hz, exb, br, mem, trap, mret, clr;
    logic [31:0] tgt, tpc, mepc;
  } stim_t;

  int n_chk  = 0;
  int n_fail = 0;

  bit          m_pend = 1'b0;
  logic [31:0] m_pc   = '0;
`ifdef FC_PERF_CNT_EN
  logic [7:0]  m_stall_cnt = '0;
  logic [7:0]  m_flush_cnt = '0;
`endif

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic drive(stim_t s);
    bus.id_ld_hazard_i = s.hz;
    bus.ex_busy_i      = s.exb;
    bus.ex_br_taken_i  = s.br;
    bus.ex_br_target_i = s.tgt;
    bus.mem_busy_i     = s.mem;
    bus.csr_trap_i     = s.trap;
    bus.csr_trap_pc_i  = s.tpc;
    bus.csr_mret_i     = s.mret;
    bus.csr_mepc_i     = s.mepc;
`ifdef FC_PERF_CNT_EN
    bus.fc_perf_clr_i  = s.clr;
`endif
  endtask

  function automatic logic [10:0] outs();
    return {bus.fc_stall_pc_o, bus.fc_stall_ifid_o,
            bus.fc_stall_idex_o, bus.fc_stall_exmem_o,
            bus.fc_stall_memwb_o,
            bus.fc_flush_ifid_o, bus.fc_flush_idex_o,
            bus.fc_flush_exmem_o, bus.fc_flush_memwb_o,
            bus.fc_redirect_o, bus.fc_busy_o};
  endfunction

  function automatic logic [3:0] overlap();
    return {bus.fc_stall_ifid_o & bus.fc_flush_ifid_o,
            bus.fc_stall_idex_o & bus.fc_flush_idex_o,
            bus.fc_stall_exmem_o & bus.fc_flush_exmem_o,
            bus.fc_stall_memwb_o & bus.fc_flush_memwb_o};
  endfunction

  // one clock: drive, compare against the rule model, advance the model
  task automatic cycle(stim_t s, string tag);
    bit sp, si, sd, se, sm, fi, fd, fe, fm, rd;
    bit req;
    logic [31:0] npc, epc;
    @(negedge clk);
    drive(s);
    #1;
    {sp, si, sd, se, sm, fi, fd, fe, fm, rd} = '0;
    epc = '0;
    req = s.trap | s.mret;
    npc = s.trap ? s.tpc : s.mepc;
    if (m_pend) begin
      if (s.mem) begin
        {sp, si, sd, se, fm} = '1;
      end else begin
        {fi, fd, fe, fm, rd} = '1;
        epc = req ? npc : m_pc;
      end
    end else if (req && !s.mem) begin
      {fi, fd, fe, fm, rd} = '1;
      epc = npc;
    end else if (s.mem) begin
      {sp, si, sd, se, fm} = '1;
    end else if (s.exb) begin
      {sp, si, sd, fe} = '1;
    end else if (s.br) begin
      {fi, fd, rd} = '1;
      epc = s.tgt;
    end else if (s.hz) begin
      {sp, si, fd} = '1;
    end
    check({tag, "/out"}, outs(),
          {sp, si, sd, se, sm, fi, fd, fe, fm, rd, m_pend});
    if (rd)
      check({tag, "/pc"}, bus.fc_redirect_pc_o, epc);
    check({tag, "/excl"}, overlap(), 4'b0);
`ifdef FC_PERF_CNT_EN
    check({tag, "/stall_cnt"}, bus.fc_stall_cyc_o, m_stall_cnt);
    check({tag, "/flush_cnt"}, bus.fc_flush_evt_o, m_flush_cnt);
    if (s.clr) begin
      m_stall_cnt = '0;
      m_flush_cnt = '0;
    end else begin
      m_stall_cnt = m_stall_cnt + 8'(sp);
      m_flush_cnt = m_flush_cnt + 8'(rd);
    end
`endif
    if (m_pend) begin
      if (!s.mem)
        m_pend = 1'b0;
      else if (s.trap)
        m_pc = s.tpc;
    end else if (req && s.mem) begin
      m_pend = 1'b1;
      m_pc   = npc;
    end
  endtask

  task automatic reset_model();
    m_pend = 1'b0;
    m_pc   = '0;
`ifdef FC_PERF_CNT_EN
    m_stall_cnt = '0;
    m_flush_cnt = '0;
`endif
  endtask

  stim_t s;
  int    busy_cnt;

  initial begin
    s = idle();
    s.trap = 1'b1;
    s.br   = 1'b1;
    s.tpc  = 32'h40;
    s.tgt  = 32'h100;
    drive(s);
    #1;
    check("rst/out", outs(), 11'b0);
    check("rst/pc", bus.fc_redirect_pc_o, 32'h0);
`ifdef FC_PERF_CNT_EN
    check("rst/cnt", {bus.fc_stall_cyc_o, bus.fc_flush_evt_o}, 16'h0);
`endif
    @(negedge clk);
    drive(idle());
    @(negedge clk);
    rst_n = 1'b1;

    s = idle(); s.hz = 1'b1;
    cycle(s, "lduse");
    cycle(idle(), "lduse_after");

    s = idle(); s.br = 1'b1; s.tgt = 32'h8000_0100;
    cycle(s, "br");

    s.mem = 1'b1;
    for (int i = 0; i < 3; i++) cycle(s, "br_mem");
    s.mem = 1'b0;
    cycle(s, "br_mem_exit");

    s = idle(); s.mem = 1'b1; s.trap = 1'b1; s.tpc = 32'h40;
    cycle(s, "trap_mem");
    busy_cnt = bus.fc_busy_o ? 1 : 0;
    s.trap = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(s, "trap_hold");
      busy_cnt += bus.fc_busy_o ? 1 : 0;
    end
    s.mem = 1'b0;
    cycle(s, "trap_exit");
    busy_cnt += bus.fc_busy_o ? 1 : 0;
    check("trap_busy_cycles", busy_cnt, 4);
    cycle(idle(), "trap_done");

    s = idle(); s.trap = 1'b1; s.mret = 1'b1;
    s.tpc = 32'h40; s.mepc = 32'h1234;
    cycle(s, "trap_mret");

    s = idle(); s.exb = 1'b1; s.trap = 1'b1; s.tpc = 32'h80;
    cycle(s, "trap_exbusy");

    s = idle(); s.mem = 1'b1; s.mret = 1'b1; s.mepc = 32'hA00;
    cycle(s, "mret_pend");
    s.mepc = 32'hB00;
    cycle(s, "mret_drop");
    s.mret = 1'b0; s.trap = 1'b1; s.tpc = 32'hC00;
    cycle(s, "trap_over");
    s.trap = 1'b0;
    cycle(s, "pend_hold");
    s.mem = 1'b0; s.mret = 1'b1; s.mepc = 32'hD00;
    cycle(s, "exit_new_mret");

    s = idle(); s.mem = 1'b1; s.trap = 1'b1; s.tpc = 32'h44;
    cycle(s, "rp_enter");
    s.trap = 1'b0;
    cycle(s, "rp_hold");
    @(negedge clk);
    drive(idle());
    rst_n = 1'b0;
    #1;
    check("rst_pend/out", outs(), 11'b0);
    reset_model();
`ifdef FC_PERF_CNT_EN
    check("rst_pend/cnt",
          {bus.fc_stall_cyc_o, bus.fc_flush_evt_o}, 16'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    cycle(idle(), "post_rst");
    cycle(idle(), "post_rst2");

    for (int i = 0; i < 3000; i++) begin
      s.hz   = ($urandom_range(99) < 25);
      s.exb  = ($urandom_range(99) < 20);
      s.br   = ($urandom_range(99) < 25);
      s.mem  = ($urandom_range(99) < 35);
      s.trap = ($urandom_range(99) < 8);
      s.mret = ($urandom_range(99) < 8);
      s.clr  = ($urandom_range(99) < 3);
      s.tgt  = $urandom;
      s.tpc  = $urandom;
      s.mepc = $urandom;
      cycle(s, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
